// File: rtl/fp16_pkg.sv
// fp16_pkg
// Shared constants and types for the binary16 (1/5/10) producers.
//   FP16_EXP_W / FP16_MAN_W : field widths
//   FP16_BIAS               : exponent bias
//   FP16_MAX_FINITE         : largest finite magnitude (used for saturation)
//   FP16_ZERO               : positive zero
//   i2f_state_t             : state encoding of the int-to-fp16 sequencer
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;
  localparam logic [15:0] FP16_ZERO       = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } i2f_state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// fp16_round_pack
// Combinational rounding and packing of a normalised 16-bit magnitude into
// an fp16 word. Reusable by any producer that can deliver a magnitude with
// its leading one in bit 15.
//   sign    : result sign
//   mag     : normalised magnitude (bit 15 set), or all-zero for a zero result
//   exp_cnt : biased exponent matching mag
//   fp16    : packed {sign, exp, man}; saturates to max finite, never infinity
// Parameter ROUND_RNE: 1 = round-to-nearest-even, 0 = truncate toward zero.
module fp16_round_pack
  import fp16_pkg::*;
#(
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic                  sign,
  input  logic [15:0]           mag,
  input  logic [FP16_EXP_W-1:0] exp_cnt,
  output logic [15:0]           fp16
);

  logic [FP16_MAN_W-1:0] man;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [FP16_MAN_W:0]   man_sum;
  logic [FP16_EXP_W:0]   exp_sum;

  always_comb begin
    man    = mag[14:5];
    guard  = mag[4];
    sticky = |mag[3:0];
    inc    = ROUND_RNE && guard && (sticky || man[0]);
    // A carry out of the mantissa leaves man_sum[9:0] at zero, which is
    // exactly the renormalised mantissa; only the exponent needs bumping.
    man_sum = {1'b0, man} + {{FP16_MAN_W{1'b0}}, inc};
    exp_sum = {1'b0, exp_cnt} + {{FP16_EXP_W{1'b0}}, man_sum[FP16_MAN_W]};

    if (!mag[15]) begin
      // No leading one means a zero input: always +0, never -0.
      fp16 = FP16_ZERO;
    end else if (exp_sum >= 6'd31) begin
      fp16 = {sign, FP16_MAX_FINITE[14:0]};
    end else begin
      fp16 = {sign, exp_sum[FP16_EXP_W-1:0], man_sum[FP16_MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/int_to_float_fp16_seq.sv
// int_to_float_fp16_seq
// Sequential 16-bit integer to fp16 converter. One conversion in flight;
// the normaliser shifts one bit per cycle until the leading one reaches
// bit 15, then a rounding cycle packs the result.
//   clk       : clock, all state on the rising edge
//   resetn    : asynchronous active-low reset
//   in_valid  / in_ready  / in_data  : input handshake and integer operand
//   out_valid / out_ready / out_data : output handshake and fp16 result
// Parameters: SIGNED (1 = two's complement input), ROUND_RNE (1 = RNE,
// 0 = truncate).
module int_to_float_fp16_seq
  import fp16_pkg::*;
#(
  parameter bit SIGNED    = 1'b1,
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  i2f_state_t            state_reg;
  logic [15:0]           data_reg;
  logic [15:0]           mag_reg;
  logic [FP16_EXP_W-1:0] exp_reg;
  logic                  sign_reg;
  logic [15:0]           out_data_reg;

  logic                  abs_sign;
  logic [15:0]           abs_mag;
  logic [15:0]           packed_fp16;

  assign abs_sign = SIGNED && data_reg[15];
  // -32768 negates to 16'h8000, which is the correct unsigned magnitude.
  assign abs_mag  = abs_sign ? (~data_reg + 16'd1) : data_reg;

  fp16_round_pack #(
    .ROUND_RNE (ROUND_RNE)
  ) u_round_pack (
    .sign    (sign_reg),
    .mag     (mag_reg),
    .exp_cnt (exp_reg),
    .fp16    (packed_fp16)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      data_reg     <= 16'h0000;
      mag_reg      <= 16'h0000;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      out_data_reg <= FP16_ZERO;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg  <= in_data;
            state_reg <= ABS;
          end
        end
        ABS: begin
          sign_reg <= abs_sign;
          mag_reg  <= abs_mag;
          // Leading one already at bit 15 means 2^15, i.e. biased 15+15.
          exp_reg  <= FP16_EXP_W'(2 * FP16_BIAS);
          // A zero magnitude skips the normaliser; the packer turns an
          // all-zero magnitude into +0, so out_data is still only written
          // on the ROUND->DONE edge.
          state_reg <= (abs_mag == 16'h0000) ? ROUND : NORM;
        end
        NORM: begin
          if (!mag_reg[15]) begin
            mag_reg <= {mag_reg[14:0], 1'b0};
            exp_reg <= exp_reg - 1'b1;
          end else begin
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          out_data_reg <= packed_fp16;
          state_reg    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset forces them immediately.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_int_to_float_fp16_seq.sv
// tb_int_to_float_fp16_seq
// Directed bench for int_to_float_fp16_seq. Three instances cover the
// parameter corners: [0] signed/RNE, [1] signed/truncate, [2] unsigned/RNE.
// Expected results are queued when an operand is driven and popped when the
// instance raises out_valid.
module tb_int_to_float_fp16_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iv   [3];
  logic        ir   [3];
  logic [15:0] id   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [15:0] od   [3];

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  int_to_float_fp16_seq #(.SIGNED(1'b1), .ROUND_RNE(1'b1)) dut_s_rne (
    .clk(clk), .resetn(resetn),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0])
  );

  int_to_float_fp16_seq #(.SIGNED(1'b1), .ROUND_RNE(1'b0)) dut_s_trn (
    .clk(clk), .resetn(resetn),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1])
  );

  int_to_float_fp16_seq #(.SIGNED(1'b0), .ROUND_RNE(1'b1)) dut_u_rne (
    .clk(clk), .resetn(resetn),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand for a single accept edge (caller ensures IDLE).
  task automatic start(input int d, input logic [15:0] din, input logic [15:0] exp_out);
    check($sformatf("in_ready_idle_d%0d", d), 32'(ir[d]), 32'd1);
    sb_q.push_back(exp_out);
    iv[d] = 1'b1;
    id[d] = din;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, then check the result.
  task automatic wait_out(input int d, input logic [15:0] din, input int lat, input string tag);
    int cyc = 0;
    logic [15:0] e;
    while (!ov[d] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    e = sb_q.pop_front();
    check({tag, "_data"}, 32'(od[d]), 32'(e));
    $display("txn %s dut=%0d in=%h out=%h exp=%h lat=%0d", tag, d, din, od[d], e, cyc);
  endtask

  task automatic handshake(input int d, input string tag);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    check({tag, "_ov_cleared"}, 32'(ov[d]), 32'd0);
    check({tag, "_in_ready_back"}, 32'(ir[d]), 32'd1);
  endtask

  task automatic convert(input int d, input logic [15:0] din, input logic [15:0] exp_out,
                         input int lat, input string tag);
    start(d, din, exp_out);
    wait_out(d, din, lat, tag);
    handshake(d, tag);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      id[k]   = 16'h0000;
      ordy[k] = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_d%0d", k), 32'(ir[k]), 32'd1);
      check($sformatf("rst_out_valid_d%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_out_data_d%0d", k), 32'(od[k]), 32'h0000);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Signed, round-to-nearest-even.
    convert(0, 16'h0001, 16'h3C00, 18, "s_one");
    convert(0, 16'hFFFF, 16'hBC00, 18, "s_minus_one");
    convert(0, 16'h0000, 16'h0000, 2,  "s_zero");
    convert(0, 16'h8000, 16'hF800, 3,  "s_min_neg");
    convert(0, 16'd2049, 16'h6800, 7,  "s_tie_even");
    convert(0, 16'd2051, 16'h6802, 7,  "s_tie_up");
    convert(0, 16'd32767, 16'h7800, 4, "s_carry");

    // Signed, truncate.
    convert(1, 16'd2051, 16'h6801, 7,  "t_2051");
    convert(1, 16'd32767, 16'h77FF, 4, "t_32767");

    // Unsigned, round-to-nearest-even.
    convert(2, 16'd65535, 16'h7BFF, 3, "u_saturate");
    convert(2, 16'd40000, 16'h78E2, 3, "u_40000");

    // Backpressure: result held while out_ready is low; busy input ignored.
    start(0, 16'd2049, 16'h6800);
    wait_out(0, 16'd2049, 7, "bp");
    iv[0] = 1'b1;
    id[0] = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_ov_hold%0d", k), 32'(ov[0]), 32'd1);
      check($sformatf("bp_od_hold%0d", k), 32'(od[0]), 32'h6800);
      check($sformatf("bp_ir_hold%0d", k), 32'(ir[0]), 32'd0);
    end
    handshake(0, "bp");
    start(0, 16'h0003, 16'h4200);
    wait_out(0, 16'h0003, 17, "b2b");
    handshake(0, "b2b");

    // Reset in the middle of normalisation aborts without a result.
    iv[0] = 1'b1;
    id[0] = 16'h0001;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_out_valid", 32'(ov[0]), 32'd0);
    check("abort_out_data", 32'(od[0]), 32'h0000);
    check("abort_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_result", 32'(ov[0]), 32'd0);
    convert(0, 16'h0003, 16'h4200, 17, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
